pong_game_ctrl: RTL and testbench

Game-level controller for the two-player Pong design. It consumes the `pts_1`/`pts_2` scoring strobes and the pixel scan position, and drives `gra_still` back into the graphics stage. It keeps both players' BCD scores, sequences new-game, serve-delay, play and game-over phases, and times the delays in video frames. Score and status outputs feed the text/score overlay and the top-level RGB mux.

---
 rtl/pong_pkg.sv | 33 +++
 rtl/bcd_counter2.sv | 25 ++
 rtl/pong_game_ctrl.sv | 100 ++++++++++
 tb/tb_pong_game_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types, defaults and helpers for the Pong game controller.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } pong_state_t;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t WIN_SCORE_DEF   = 8'h11;
  localparam int    HOLD_FRAMES_DEF = 120;
  localparam int    TICK_Y_DEF      = 481;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd9) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with synchronous clear (dominant) and increment-enable.
module bcd_counter2
  import pong_pkg::*;
(
  input  logic  clk,
  input  logic  clr_i,
  input  logic  inc_i,
  output bcd2_t count_o
);

  bcd2_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = 8'h00;
    else if (inc_i) count_d = bcd_inc(count_q);
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-level FSM: scores, serve delay, game-over hold, frame-tick timer.
// Optional manual serve after a point is enabled by defining PONG_CTRL_SERVE_BTN_EN.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter bcd2_t WIN_SCORE   = WIN_SCORE_DEF,
  parameter int    HOLD_FRAMES = HOLD_FRAMES_DEF,
  parameter int    TICK_Y      = TICK_Y_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        pts_1,
  input  logic        pts_2,
  output logic        gra_still,
  output logic [7:0]  score_1,
  output logic [7:0]  score_2,
  output logic        game_over,
  output logic [1:0]  winner,
  output pong_state_t dbg_state,
  output logic [7:0]  dbg_timer
);

  pong_state_t state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  winner_q, winner_d;

  logic ftick, timer_done, serve_ok, over_exit;
  logic pt1, pt2, win1, win2, score_clr;

  assign ftick      = (y == 10'(TICK_Y)) && (x == 10'd0);
  assign timer_done = (timer_q == 8'd0);

`ifdef PONG_CTRL_SERVE_BTN_EN
  assign serve_ok = timer_done && (|btn);
`else
  assign serve_ok = timer_done;
`endif

  // Strobes count only in PLAY; player 1 takes priority on a same-cycle tie.
  assign pt1       = (state_q == ST_PLAY) && pts_1;
  assign pt2       = (state_q == ST_PLAY) && pts_2 && !pts_1;
  assign win1      = (bcd_inc(score_1) == WIN_SCORE);
  assign win2      = (bcd_inc(score_2) == WIN_SCORE);
  assign over_exit = (state_q == ST_OVER) && timer_done;
  assign score_clr = reset || over_exit;

  bcd_counter2 u_score_1 (.clk(clk), .clr_i(score_clr), .inc_i(pt1), .count_o(score_1));
  bcd_counter2 u_score_2 (.clk(clk), .clr_i(score_clr), .inc_i(pt2), .count_o(score_2));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_NEWGAME;
      timer_q  <= 8'd0;
      winner_q <= WIN_NONE;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NEWGAME: if (|btn) state_d = ST_PLAY;
      ST_PLAY: begin
        if (pt1)      state_d = win1 ? ST_OVER : ST_NEWBALL;
        else if (pt2) state_d = win2 ? ST_OVER : ST_NEWBALL;
      end
      ST_NEWBALL: if (serve_ok) state_d = ST_PLAY;
      ST_OVER:    if (timer_done) state_d = ST_NEWGAME;
      default:    state_d = ST_NEWGAME;
    endcase
  end

  always_comb begin
    timer_d  = timer_q;
    winner_d = winner_q;
    if (pt1 || pt2)
      timer_d = 8'(HOLD_FRAMES);
    else if ((state_q == ST_NEWBALL || state_q == ST_OVER) && ftick && !timer_done)
      timer_d = timer_q - 8'd1;
    if (pt1 && win1)      winner_d = WIN_P1;
    else if (pt2 && win2) winner_d = WIN_P2;
    if (over_exit)        winner_d = WIN_NONE;
  end

  always_comb begin
    gra_still = (state_q != ST_PLAY);
    game_over = (state_q == ST_OVER);
  end

  assign winner    = winner_q;
  assign dbg_state = state_q;
  assign dbg_timer = timer_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: scoring, BCD carry, win, timers, reset.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn;
  logic [9:0]  x, y;
  logic        pts_1, pts_2;
  logic        gra_still, game_over;
  logic [7:0]  score_1, score_2;
  logic [1:0]  winner;
  pong_state_t dbg_state;
  logic [7:0]  dbg_timer;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk(clk), .reset(reset), .btn(btn), .x(x), .y(y),
    .pts_1(pts_1), .pts_2(pts_2), .gra_still(gra_still),
    .score_1(score_1), .score_2(score_2), .game_over(game_over),
    .winner(winner), .dbg_state(dbg_state), .dbg_timer(dbg_timer)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Two idle cycles then one frame-tick cycle.
  task automatic frame();
    x = 10'd5; y = 10'd0;
    tick(2);
    x = 10'd0; y = 10'd481;
    tick(1);
    x = 10'd5; y = 10'd0;
  endtask

  task automatic serve();
    repeat (120) frame();
    btn = 4'b0100;
    tick(1);
    btn = 4'b0000;
  endtask

  task automatic pulse_p1();
    pts_1 = 1'b1;
    tick(1);
    pts_1 = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; btn = 4'b0; x = 10'd5; y = 10'd0; pts_1 = 1'b0; pts_2 = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("rst_state", 32'(dbg_state), 32'(ST_NEWGAME));
    chk("rst_still", 32'(gra_still), 32'd1);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_s1", 32'(score_1), 32'h00);
    chk("rst_s2", 32'(score_2), 32'h00);
    chk("rst_win", 32'(winner), 32'd0);
    chk("rst_timer", 32'(dbg_timer), 32'd0);

    repeat (3) frame();
    chk("idle_state", 32'(dbg_state), 32'(ST_NEWGAME));
    chk("idle_still", 32'(gra_still), 32'd1);

    btn = 4'b0001;
    tick(1);
    btn = 4'b0000;
    chk("start_state", 32'(dbg_state), 32'(ST_PLAY));
    chk("start_still", 32'(gra_still), 32'd0);

    // Held strobe must count once.
    pts_2 = 1'b1;
    tick(5);
    pts_2 = 1'b0;
    chk("p2_score", 32'(score_2), 32'h01);
    chk("p2_s1", 32'(score_1), 32'h00);
    chk("p2_state", 32'(dbg_state), 32'(ST_NEWBALL));
    chk("p2_still", 32'(gra_still), 32'd1);
    chk("p2_timer", 32'(dbg_timer), 32'd120);

    repeat (119) frame();
    chk("nb_timer1", 32'(dbg_timer), 32'd1);
    chk("nb_state1", 32'(dbg_state), 32'(ST_NEWBALL));
    frame();
    chk("nb_timer0", 32'(dbg_timer), 32'd0);
    chk("nb_state0", 32'(dbg_state), 32'(ST_NEWBALL));
`ifdef PONG_CTRL_SERVE_BTN_EN
    repeat (500) frame();
    chk("wait_state", 32'(dbg_state), 32'(ST_NEWBALL));
    chk("wait_still", 32'(gra_still), 32'd1);
    btn = 4'b0100;
    tick(1);
    btn = 4'b0000;
`else
    tick(1);
`endif
    chk("serve_state", 32'(dbg_state), 32'(ST_PLAY));
    chk("serve_still", 32'(gra_still), 32'd0);

    pts_1 = 1'b1; pts_2 = 1'b1;
    tick(1);
    pts_1 = 1'b0; pts_2 = 1'b0;
    chk("tie_s1", 32'(score_1), 32'h01);
    chk("tie_s2", 32'(score_2), 32'h01);
    serve();

    repeat (8) begin
      pulse_p1();
      serve();
    end
    chk("s1_09", 32'(score_1), 32'h09);
    chk("s1_09_state", 32'(dbg_state), 32'(ST_PLAY));

    pulse_p1();
    chk("carry_s1", 32'(score_1), 32'h10);
    chk("carry_state", 32'(dbg_state), 32'(ST_NEWBALL));
    serve();

    pts_1 = 1'b1;
    tick(3);
    pts_1 = 1'b0;
    chk("win_s1", 32'(score_1), 32'h11);
    chk("win_state", 32'(dbg_state), 32'(ST_OVER));
    chk("win_winner", 32'(winner), 32'd1);
    chk("win_over", 32'(game_over), 32'd1);
    chk("win_still", 32'(gra_still), 32'd1);
    chk("win_timer", 32'(dbg_timer), 32'd120);

    repeat (120) frame();
    chk("over_hold", 32'(dbg_state), 32'(ST_OVER));
    tick(1);
    chk("ng_state", 32'(dbg_state), 32'(ST_NEWGAME));
    chk("ng_s1", 32'(score_1), 32'h00);
    chk("ng_s2", 32'(score_2), 32'h00);
    chk("ng_winner", 32'(winner), 32'd0);
    chk("ng_over", 32'(game_over), 32'd0);

    btn = 4'b1000;
    tick(1);
    btn = 4'b0000;
    pulse_p1();
    repeat (63) frame();
    chk("mid_timer", 32'(dbg_timer), 32'd57);
    chk("mid_s1", 32'(score_1), 32'h01);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mrst_state", 32'(dbg_state), 32'(ST_NEWGAME));
    chk("mrst_timer", 32'(dbg_timer), 32'd0);
    chk("mrst_s1", 32'(score_1), 32'h00);
    chk("mrst_still", 32'(gra_still), 32'd1);
    chk("mrst_winner", 32'(winner), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
